// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control for the 32-bit MIPS datapath.
// Decodes ALUOp/funct into an ALU select code and sequences the multi-cycle
// MUL/DIV operations: the select code is held while the operation runs, its
// latency is counted down, and further issue is stalled until it completes.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_sel,
  output logic              sel_valid,
  output logic              multi_busy,
  output logic              illegal,
  output logic              stall
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Counter load values: the counter starts at latency-1 and the op
  // completes on the edge where it steps from 1 down to 0.
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_sel;
  logic             dec_illegal;
  logic             dec_mul;
  logic             dec_div;
  logic             go_busy;
  logic [CNT_W-1:0] busy_cnt;
  logic             accept;
  logic             unused_funct_hi;

  // The upper funct bits do not take part in the decode.
  assign unused_funct_hi = ^funct[5:4];

  assign op_ready = (state == IDLE) & ~flush;
  assign accept   = op_valid & op_ready;
  assign stall    = op_valid & ~op_ready;

  // Translate ALUOp/funct into the 4-bit select code and classify the op.
  always_comb begin
    dec_sel     = 4'b0000;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    case (alu_op)
      2'b00:   dec_sel = 4'b0010;
      2'b01:   dec_sel = 4'b0110;
      default: begin
        case (funct[3:0])
          4'b0000: dec_sel = 4'b0010;
          4'b0010: dec_sel = 4'b0110;
          4'b0100: dec_sel = 4'b0000;
          4'b0101: dec_sel = 4'b0001;
          4'b0110: dec_sel = 4'b0100;
          4'b0111: dec_sel = 4'b0011;
          4'b1010: dec_sel = 4'b0111;
          4'b1000: begin
            dec_sel = 4'b1010;
            dec_mul = 1'b1;
          end
          4'b1111: begin
            dec_sel = 4'b1111;
            dec_div = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Decide whether the decoded op needs the multi-cycle sequencer and with
  // what counter start value; a latency of 1 behaves like a plain ALU op.
  always_comb begin
    go_busy  = 1'b0;
    busy_cnt = '0;
    if (dec_mul && (MUL_CYCLES > 1)) begin
      go_busy  = 1'b1;
      busy_cnt = MUL_LAST;
    end else if (dec_div && (DIV_CYCLES > 1)) begin
      go_busy  = 1'b1;
      busy_cnt = DIV_LAST;
    end
  end

  // IDLE/BUSY sequencer: flush aborts anything in flight, IDLE issues ops,
  // BUSY counts down and fires sel_valid when the latency has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_sel    <= '0;
      sel_valid  <= 1'b0;
      multi_busy <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_valid  <= 1'b0;
      multi_busy <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        alu_sel <= CTRL_W'(dec_sel);
        illegal <= dec_illegal;
        if (go_busy) begin
          state      <= BUSY;
          cnt        <= busy_cnt;
          multi_busy <= 1'b1;
          sel_valid  <= 1'b0;
        end else begin
          sel_valid <= 1'b1;
        end
      end else begin
        sel_valid <= 1'b0;
      end
    end else begin
      if (cnt == CNT_ONE) begin
        state      <= IDLE;
        cnt        <= '0;
        multi_busy <= 1'b0;
        sel_valid  <= 1'b1;
      end else begin
        cnt       <= cnt - CNT_ONE;
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and randomized bench for alu_ctrl_seq, checked
// against a transaction-level model that tracks the completion cycle of the
// op in flight rather than any internal counter or state.
module tb_alu_ctrl_seq;

  localparam int CTRL_W     = 4;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 6;

  logic              clk;
  logic              rst_n;
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              flush;
  logic [CTRL_W-1:0] alu_sel;
  logic              sel_valid;
  logic              multi_busy;
  logic              illegal;
  logic              stall;

  int checks = 0;
  int errors = 0;

  // Model: cycle number, cycle on which the in-flight op completes (-1 if
  // none), and the select/illegal values last registered by an accept.
  int         now     = 0;
  int         done_at = -1;
  logic [3:0] cur_sel = 4'b0000;
  logic       cur_ill = 1'b0;
  int         sel_of[int];
  logic [5:0] legal_f[9];

  alu_ctrl_seq #(
    .CTRL_W    (CTRL_W),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .flush     (flush),
    .alu_sel   (alu_sel),
    .sel_valid (sel_valid),
    .multi_busy(multi_busy),
    .illegal   (illegal),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask

  // Spec decode table applied to one request: select code, illegal flag and
  // the number of cycles until its result completes.
  function automatic void refDecode(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] sel, output logic ill,
                                    output int lat);
    int key;
    int s;
    key = int'(f[3:0]);
    sel = 4'b0000;
    ill = 1'b0;
    lat = 1;
    if (op == 2'b00) sel = 4'b0010;
    else if (op == 2'b01) sel = 4'b0110;
    else if (sel_of.exists(key)) begin
      s   = sel_of[key];
      sel = s[3:0];
      if (key == 8) lat = MUL_CYCLES;
      if (key == 15) lat = DIV_CYCLES;
    end else begin
      ill = 1'b1;
    end
  endfunction

  task automatic checkOutput();
    logic exp_busy;
    logic exp_rdy;
    exp_busy = (done_at > now);
    exp_rdy  = !exp_busy && !flush;
    cmp("op_ready", op_ready, exp_rdy);
    cmp("stall", stall, op_valid && !exp_rdy);
    cmp("multi_busy", multi_busy, exp_busy);
    cmp("sel_valid", sel_valid, (done_at == now));
    cmp("alu_sel", alu_sel, CTRL_W'(cur_sel));
    cmp("illegal", illegal, cur_ill);
  endtask

  // What the rising edge that ends the current cycle does to the model.
  task automatic advanceModel();
    logic [3:0] s;
    logic       il;
    int         lat;
    if (flush) begin
      done_at = -1;
    end else if (op_valid && !(done_at > now)) begin
      refDecode(alu_op, funct, s, il, lat);
      cur_sel = s;
      cur_ill = il;
      done_at = now + lat;
    end
    now++;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [5:0] f, input logic fl);
    @(negedge clk);
    op_valid = v;
    alu_op   = op;
    funct    = f;
    flush    = fl;
    #1;
    checkOutput();
    advanceModel();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 6'h00, 1'b0);
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    flush    = 1'b0;
    #1;
    done_at = -1;
    cur_sel = 4'b0000;
    cur_ill = 1'b0;
    checkOutput();
    @(negedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
  endtask

  // Directed scenarios followed by a randomized run, then the summary.
  initial begin
    sel_of[0]  = 4'b0010;
    sel_of[2]  = 4'b0110;
    sel_of[4]  = 4'b0000;
    sel_of[5]  = 4'b0001;
    sel_of[6]  = 4'b0100;
    sel_of[7]  = 4'b0011;
    sel_of[10] = 4'b0111;
    sel_of[8]  = 4'b1010;
    sel_of[15] = 4'b1111;
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h18, 6'h1f};

    rst_n    = 1'b0;
    op_valid = 1'b0;
    alu_op   = 2'b00;
    funct    = 6'h00;
    flush    = 1'b0;

    // Held in reset: outputs cleared, op_ready follows ~flush.
    #12;
    checkOutput();
    flush = 1'b1;
    #1;
    checkOutput();
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Single ADD via alu_op=00.
    applyStimulus(1'b1, 2'b00, 6'h00, 1'b0);
    idleCycles(1);

    // Back-to-back R-type issue.
    applyStimulus(1'b1, 2'b10, 6'b100000, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100010, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b100101, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'b101010, 1'b0);
    idleCycles(1);

    // MUL with op_valid held: second MUL taken when the first completes.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b10, 6'b011000, 1'b0);
    idleCycles(4);

    // DIV aborted by flush, then DIV aborted by reset.
    applyStimulus(1'b1, 2'b10, 6'b011111, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 2'b00, 6'h00, 1'b1);
    idleCycles(2);
    applyStimulus(1'b1, 2'b10, 6'b011111, 1'b0);
    idleCycles(3);
    doReset();
    idleCycles(2);

    // Illegal funct, and alu_op=11 decoding like 10.
    applyStimulus(1'b1, 2'b10, 6'b000001, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 2'b11, 6'b100100, 1'b0);
    idleCycles(1);

    // Flush and request together in IDLE: request dropped.
    applyStimulus(1'b1, 2'b00, 6'h00, 1'b1);
    idleCycles(2);

    $display("[TB] directed steps done, starting random run");
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = legal_f[$urandom_range(0, 8)];
      applyStimulus(1'($urandom_range(0, 2) != 0), 2'($urandom), f,
                    1'($urandom_range(0, 19) == 0));
    end
    idleCycles(DIV_CYCLES + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
